stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter n, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, minimum 2.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 push  input  1  write din onto the stack this cycle.
REQ-006 pop  input  1  remove the top entry this cycle.
REQ-007 din  input  n  data to push.
REQ-008 tos  output  n  current top-of-stack entry.
REQ-009 tos2  output  n  entry directly below the top (second ALU operand).
REQ-010 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-011 empty  output  1  high when count == 0.
REQ-012 full  output  1  high when count == DEPTH.
REQ-013 err  output  1  sticky illegal-operation flag; present only under STACK_ERR_EN.

Function
REQ-014 All state (storage array, stack pointer, err) SHALL update only on the rising edge of clk.
REQ-015 tos, tos2, empty, full and count SHALL be combinational decodes of registered state, with no input-to-output combinational path.
REQ-016 Push only, not full: store din at index count; count += 1; new tos = din from the next cycle.
REQ-017 Pop only, not empty: count -= 1; popped storage contents need not be cleared.
REQ-018 Push and pop together, not empty: replace the top entry with din; count unchanged; legal even when full.
REQ-019 Push and pop together, empty: perform the push only (count becomes 1); flag an underflow.
REQ-020 Push only, full: no state change except err; overflow.
REQ-021 Pop only, empty: no state change except err; underflow.
REQ-022 Neither push nor pop: hold all state.
REQ-023 tos SHALL be 0 when empty; tos2 SHALL be 0 when count < 2.
REQ-024 Latency: an operation sampled on edge k SHALL be visible on tos, tos2 and count immediately after edge k.
REQ-025 count SHALL never exceed DEPTH or go below 0; there is no wrap-around.

Reset
REQ-026 rst high at a clock edge SHALL force count = 0 (so empty = 1, full = 0, tos = 0, tos2 = 0) and err = 0, overriding push and pop on the same edge.
REQ-027 Storage array contents need not be cleared by reset.
REQ-028 Deasserting rst mid-sequence SHALL leave the stack empty, with the first push accepted on the first edge after deassertion.

Configuration
REQ-029 Macro STACK_ERR_EN defined: the err port exists and is set on any overflow or underflow event (REQ-019, REQ-020, REQ-021).
REQ-030 Once set, err SHALL stay set until rst.
REQ-031 Macro STACK_ERR_EN undefined: the err port and its register are absent; illegal operations are silently ignored as specified above.
REQ-032 All other behaviour SHALL be identical with and without STACK_ERR_EN.

Verification
REQ-033 Reset, then push 0x11, 0x22, 0x33 -> count = 3, tos = 0x33, tos2 = 0x22, empty = 0.
REQ-034 From REQ-033 state, push+pop with din = 0x44 -> count = 3, tos = 0x44, tos2 = 0x22.
REQ-035 Push 8 values (DEPTH = 8), then push 0xAA -> full = 1, count = 8, tos unchanged, err = 1 (STACK_ERR_EN).
REQ-036 Reset, then pop -> count = 0, tos = 0, err = 1; next, push+pop with din = 0x5A -> count = 1, tos = 0x5A.
REQ-037 Push 0x11 and 0x22, then assert rst together with push 0x99 -> count = 0, tos = 0, err = 0 on the following cycle.
REQ-038 Build without STACK_ERR_EN and rerun REQ-035 and REQ-036 -> identical count and tos results; no err port.

Source files
------------

// File: rtl/stack_unit.sv
// LIFO operand stack with registered pointer and decoded top/second outputs.
// Define STACK_ERR_EN to add the sticky err flag for overflow/underflow.
module stack_unit #(
  parameter int n     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [n-1:0]               din,
  output logic [n-1:0]               tos,
  output logic [n-1:0]               tos2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
`ifdef STACK_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [n-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] sec_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;

  assign top_idx = AW'(cnt_q - CW'(1));
  assign sec_idx = AW'(cnt_q - CW'(2));
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign tos     = empty ? '0 : mem[top_idx];
  assign tos2    = (cnt_q < CW'(2)) ? '0 : mem[sec_idx];

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = cnt_q[AW-1:0];
    cnt_d  = cnt_q;
    unique case (1'b1)
      push && pop && !empty: begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
      push && pop && empty: begin
        wr_en  = 1'b1;
        wr_idx = '0;
        cnt_d  = CW'(1);
      end
      push && !pop && !full: begin
        wr_en  = 1'b1;
        cnt_d  = cnt_q + CW'(1);
      end
      pop && !push && !empty: begin
        cnt_d  = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // storage is never cleared; validity is tracked by cnt_q alone
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_idx] <= din;
    end
  end

`ifdef STACK_ERR_EN
  logic bad;
  assign bad = (push && !pop && full) || (pop && empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (bad) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a behavioural stack model queues the
// expected outputs per operation; they are compared after each clock edge.
module tb_stack_unit;

  typedef struct packed {
    logic [3:0] c;
    logic [7:0] t;
    logic [7:0] t2;
    logic       e;
    logic       f;
    logic       er;
  } exp_t;

  typedef struct packed {
    logic       r;
    logic       p;
    logic       q;
    logic [7:0] d;
  } st_t;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [7:0] din;
  logic [7:0] tos;
  logic [7:0] tos2;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       err_v;

  int   errs   = 0;
  int   checks = 0;
  exp_t sb[$];

  logic [7:0] m [8];
  int         mc   = 0;
  logic       merr = 1'b0;

`ifdef STACK_ERR_EN
  logic err;
  assign err_v = err;
`else
  assign err_v = 1'b0;
`endif

  stack_unit #(.n(8), .DEPTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .tos   (tos),
    .tos2  (tos2),
    .count (count),
    .empty (empty),
    .full  (full)
`ifdef STACK_ERR_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic op(input st_t s);
    exp_t e;
    rst  = s.r;
    push = s.p;
    pop  = s.q;
    din  = s.d;
    if (s.r) begin
      mc   = 0;
      merr = 1'b0;
    end else if (s.p && s.q) begin
      if (mc == 0) begin
        m[0] = s.d;
        mc   = 1;
        merr = 1'b1;
      end else begin
        m[mc-1] = s.d;
      end
    end else if (s.p) begin
      if (mc < 8) begin
        m[mc] = s.d;
        mc    = mc + 1;
      end else begin
        merr = 1'b1;
      end
    end else if (s.q) begin
      if (mc > 0) mc = mc - 1;
      else merr = 1'b1;
    end
    e.c  = 4'(mc);
    e.t  = (mc > 0) ? m[mc-1] : 8'h00;
    e.t2 = (mc > 1) ? m[mc-2] : 8'h00;
    e.e  = (mc == 0);
    e.f  = (mc == 8);
`ifdef STACK_ERR_EN
    e.er = merr;
`else
    e.er = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic run(input string name, input st_t s[$]);
    exp_t e;
    exp_t g;
    for (int i = 0; i < s.size(); i++) begin
      op(s[i]);
      e = sb.pop_front();
      g = {count, tos, tos2, empty, full, err_v};
      checks++;
      if (g !== e) begin
        errs++;
        $display("FAIL %s step%0d: got cnt=%0d tos=%h tos2=%h emp=%b full=%b err=%b want cnt=%0d tos=%h tos2=%h emp=%b full=%b err=%b",
                 name, i, g.c, g.t, g.t2, g.e, g.f, g.er,
                 e.c, e.t, e.t2, e.e, e.f, e.er);
      end
    end
  endtask

  task automatic test_reset();
    st_t s[$];
    s.push_back('{1, 0, 0, 8'h00});
    s.push_back('{0, 0, 0, 8'h00});
    run("reset", s);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0
        || tos !== 8'h00 || tos2 !== 8'h00 || err_v !== 1'b0) begin
      errs++;
      $display("FAIL reset_const: got cnt=%0d emp=%b full=%b tos=%h tos2=%h err=%b want 0 1 0 00 00 0",
               count, empty, full, tos, tos2, err_v);
    end
  endtask

  task automatic test_push_replace();
    st_t s[$];
    s.push_back('{1, 0, 0, 8'h00});
    s.push_back('{0, 1, 0, 8'h11});
    s.push_back('{0, 1, 0, 8'h22});
    s.push_back('{0, 1, 0, 8'h33});
    run("push3", s);
    checks++;
    if (count !== 4'd3 || tos !== 8'h33 || tos2 !== 8'h22 || empty !== 1'b0) begin
      errs++;
      $display("FAIL push3_const: got cnt=%0d tos=%h tos2=%h emp=%b want 3 33 22 0",
               count, tos, tos2, empty);
    end
    s.delete();
    s.push_back('{0, 1, 1, 8'h44});
    run("replace", s);
    checks++;
    if (count !== 4'd3 || tos !== 8'h44 || tos2 !== 8'h22) begin
      errs++;
      $display("FAIL replace_const: got cnt=%0d tos=%h tos2=%h want 3 44 22",
               count, tos, tos2);
    end
  endtask

  task automatic test_overflow();
    st_t s[$];
    logic [7:0] top;
    s.push_back('{1, 0, 0, 8'h00});
    for (int i = 0; i < 8; i++) s.push_back('{0, 1, 0, 8'(8'hC0 + i)});
    run("fill", s);
    top = tos;
    s.delete();
    s.push_back('{0, 1, 0, 8'hAA});
    s.push_back('{0, 1, 1, 8'hBB});
    run("overflow", s);
    checks++;
`ifdef STACK_ERR_EN
    if (full !== 1'b1 || count !== 4'd8 || tos !== 8'hBB || err_v !== 1'b1) begin
`else
    if (full !== 1'b1 || count !== 4'd8 || tos !== 8'hBB || err_v !== 1'b0) begin
`endif
      errs++;
      $display("FAIL overflow_const: got full=%b cnt=%0d tos=%h err=%b want 1 8 bb (prev top %h)",
               full, count, tos, err_v, top);
    end
  endtask

  task automatic test_underflow();
    st_t s[$];
    s.push_back('{1, 0, 0, 8'h00});
    s.push_back('{0, 0, 1, 8'h00});
    s.push_back('{0, 1, 1, 8'h5A});
    s.push_back('{0, 0, 1, 8'h00});
    s.push_back('{0, 0, 1, 8'h00});
    run("underflow", s);
    checks++;
    if (count !== 4'd0 || tos !== 8'h00 || empty !== 1'b1) begin
      errs++;
      $display("FAIL underflow_const: got cnt=%0d tos=%h emp=%b want 0 00 1",
               count, tos, empty);
    end
  endtask

  task automatic test_reset_override();
    st_t s[$];
    s.push_back('{1, 0, 0, 8'h00});
    s.push_back('{0, 0, 1, 8'h00});
    s.push_back('{0, 1, 0, 8'h11});
    s.push_back('{0, 1, 0, 8'h22});
    s.push_back('{1, 1, 0, 8'h99});
    s.push_back('{0, 1, 0, 8'h77});
    run("rst_override", s);
    checks++;
    if (count !== 4'd1 || tos !== 8'h77 || tos2 !== 8'h00 || err_v !== 1'b0) begin
      errs++;
      $display("FAIL rst_override_const: got cnt=%0d tos=%h tos2=%h err=%b want 1 77 00 0",
               count, tos, tos2, err_v);
    end
  endtask

  task automatic test_back_to_back();
    st_t s[$];
    for (int i = 0; i < 200; i++) begin
      s.push_back('{($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom),
                    8'($urandom)});
    end
    run("b2b", s);
  endtask

  initial begin
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    din  = 8'h00;
    test_reset();
    test_push_replace();
    test_overflow();
    test_underflow();
    test_reset_override();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
